paralelo_serie_bc: RTL and testbench



---
 rtl/ps_pkg.sv | 12 +
 rtl/ps_bit_counter.sv | 22 ++
 rtl/paralelo_serie_bc.sv | 88 ++++++++
 tb/tb_paralelo_serie_bc.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ps_pkg.sv
// rtl/ps_pkg.sv - shared comma symbol, state encoding and counter width for the serial link
package ps_pkg;

  localparam logic [7:0] COMMA_BC  = 8'hBC;
  localparam int         BIT_CNT_W = 3;

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } ps_state_t;

endpackage

// File: rtl/ps_bit_counter.sv
// rtl/ps_bit_counter.sv - free-running 3-bit bit position counter with byte-boundary decode
module ps_bit_counter
  import ps_pkg::*;
(
  input  logic                 clk_8f,
  input  logic                 reset,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 load
);

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // The next edge is a byte boundary whenever the counter sits at zero.
  assign load = (bit_cnt == '0);

endmodule

// File: rtl/paralelo_serie_bc.sv
// rtl/paralelo_serie_bc.sv - MSB-first serializer with 0xBC comma fill; PS_STATS_EN adds tx_count/comma_seen
module paralelo_serie_bc
  import ps_pkg::*;
#(
  parameter logic [7:0] COMMA       = COMMA_BC,
  parameter int         SYNC_COMMAS = 4
) (
  input  logic        clk_8f,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic        data_out,
  output logic        data_ack,
  output logic        load,
  output logic        active
`ifdef PS_STATS_EN
  ,
  output logic [15:0] tx_count,
  output logic        comma_seen
`endif
);

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_COMMAS - 1);

  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [7:0]           shift_reg;
  logic [3:0]           sync_cnt;
  ps_state_t            state;
  logic [7:0]           word;
  logic                 take;

  ps_bit_counter u_bit_counter (
    .clk_8f  (clk_8f),
    .reset   (reset),
    .bit_cnt (bit_cnt),
    .load    (load)
  );

  // Data is only eligible once alignment commas are done; otherwise fill with the comma.
  always_comb begin
    take = 1'b0;
    word = COMMA;
    if (state == ST_ACTIVE && valid_in) begin
      take = 1'b1;
      word = data_in;
    end
  end

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      state     <= ST_SYNC;
      sync_cnt  <= '0;
      shift_reg <= COMMA;
      data_out  <= 1'b0;
      data_ack  <= 1'b0;
      active    <= 1'b0;
    end else if (load) begin
      shift_reg <= word;
      data_out  <= word[7];
      data_ack  <= take;
      if (state == ST_SYNC) begin
        sync_cnt <= sync_cnt + 4'd1;
        if (sync_cnt == SYNC_LAST) begin
          state  <= ST_ACTIVE;
          active <= 1'b1;
        end
      end
    end else begin
      data_out <= shift_reg[3'd7 - bit_cnt];
      data_ack <= 1'b0;
    end
  end

`ifdef PS_STATS_EN
  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      tx_count   <= '0;
      comma_seen <= 1'b0;
    end else begin
      if (data_ack && tx_count != 16'hFFFF) begin
        tx_count <= tx_count + 16'd1;
      end
      comma_seen <= load && (word == COMMA);
    end
  end
`endif

endmodule

// File: tb/tb_paralelo_serie_bc.sv
// tb/tb_paralelo_serie_bc.sv - directed scoreboard bench for paralelo_serie_bc
module tb_paralelo_serie_bc;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam int         SYNC  = 4;

  logic       clk_8f;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       data_out;
  logic       data_ack;
  logic       load;
  logic       active;
`ifdef PS_STATS_EN
  logic [15:0] tx_count;
  logic        comma_seen;
`endif

  int   checks = 0;
  int   errors = 0;
  int   nbound = 0;
  int   exp_acks = 0;
  logic sb[$];

  paralelo_serie_bc #(.COMMA(COMMA), .SYNC_COMMAS(SYNC)) dut (
    .clk_8f   (clk_8f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .data_out (data_out),
    .data_ack (data_ack),
    .load     (load),
    .active   (active)
`ifdef PS_STATS_EN
    ,
    .tx_count   (tx_count),
    .comma_seen (comma_seen)
`endif
  );

  initial clk_8f = 1'b0;
  always #5 clk_8f = ~clk_8f;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one byte period starting at a negedge where the next edge is a boundary.
  // chg_at > 0 swaps data_in to d2 during the cycle where bit_cnt == chg_at.
  task automatic byte_step(input logic v, input logic [7:0] d, input int chg_at, input logic [7:0] d2);
    logic [7:0] w;
    logic       ack;
    logic       b;
    check("load_at_boundary", 16'(load), 16'd1);
    valid_in = v;
    data_in  = d;
    if (nbound < SYNC) begin
      w = COMMA; ack = 1'b0;
    end else if (v) begin
      w = d; ack = 1'b1;
    end else begin
      w = COMMA; ack = 1'b0;
    end
    for (int i = 7; i >= 0; i--) sb.push_back(w[i]);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_8f);
      @(negedge clk_8f);
      if (chg_at > 0 && k + 1 == chg_at) data_in = d2;
      b = sb.pop_front();
      check("data_out", 16'(data_out), 16'(b));
      check("data_ack", 16'(data_ack), (k == 0) ? 16'(ack) : 16'd0);
      if (k == 0) check("active", 16'(active), (nbound >= SYNC - 1) ? 16'd1 : 16'd0);
    end
    if (ack) exp_acks++;
`ifdef PS_STATS_EN
    check("tx_count", tx_count, 16'(exp_acks));
`endif
    nbound++;
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    repeat (2) @(posedge clk_8f);
    @(negedge clk_8f);
    check("rst_data_out", 16'(data_out), 16'd0);
    check("rst_data_ack", 16'(data_ack), 16'd0);
    check("rst_active", 16'(active), 16'd0);
    check("rst_load", 16'(load), 16'd1);
    reset = 1'b0;

    // Idle after reset: six commas, active rises at boundary 3.
    for (int i = 0; i < 6; i++) byte_step(1'b0, 8'h00, 0, 8'h00);

    // Back-to-back data words.
    byte_step(1'b1, 8'hFF, 0, 8'h00);
    byte_step(1'b1, 8'hEE, 0, 8'h00);
    byte_step(1'b1, 8'h4E, 0, 8'h00);

    // Alternating valid with 0x90, and a valid word equal to the comma.
    for (int i = 0; i < 4; i++) byte_step(i[0] == 1'b0, 8'h90, 0, 8'h00);
    byte_step(1'b1, COMMA, 0, 8'h00);

    // Mid-byte data change must not affect the word in flight.
    byte_step(1'b1, 8'h44, 3, 8'h11);
    byte_step(1'b1, 8'h11, 0, 8'h00);

    // Reset in the middle of a data word.
    valid_in = 1'b1;
    data_in  = 8'hFF;
    repeat (5) @(posedge clk_8f);
    @(negedge clk_8f);
    reset = 1'b1;
    #1;
    check("midrst_data_out", 16'(data_out), 16'd0);
    check("midrst_data_ack", 16'(data_ack), 16'd0);
    check("midrst_active", 16'(active), 16'd0);
    check("midrst_load", 16'(load), 16'd1);
`ifdef PS_STATS_EN
    check("midrst_tx_count", tx_count, 16'd0);
    exp_acks = 0;
`endif
    @(posedge clk_8f);
    @(negedge clk_8f);
    reset  = 1'b0;
    nbound = 0;

    // A2 offered during SYNC is ignored, then sent once active.
    for (int i = 0; i < SYNC; i++) byte_step(1'b1, 8'hA2, 0, 8'h00);
    byte_step(1'b1, 8'hA2, 0, 8'h00);
    byte_step(1'b0, 8'h00, 0, 8'h00);

    check("sb_empty", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
